// File: rtl/apf_wb_pkg.sv
// apf_wb_pkg: shared types for the APF Wishbone read/write master.
// Holds the FSM state, the queued command record and the byte-swap helpers.
package apf_wb_pkg;

  localparam int WB_ADDR_W = 30;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = WB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  typedef struct packed {
    logic                 we;
    logic                 swap;
    logic [WB_SEL_W-1:0]  sel;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } cmd_t;

  function automatic logic [WB_DATA_W-1:0] byte_rev(
    input logic [WB_DATA_W-1:0] d
  );
    logic [WB_DATA_W-1:0] r;
    for (int i = 0; i < WB_SEL_W; i++) begin
      r[8*i +: 8] = d[8*(WB_SEL_W-1-i) +: 8];
    end
    return r;
  endfunction

  function automatic logic [WB_SEL_W-1:0] sel_rev(
    input logic [WB_SEL_W-1:0] s
  );
    logic [WB_SEL_W-1:0] r;
    for (int i = 0; i < WB_SEL_W; i++) begin
      r[i] = s[WB_SEL_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/apf_wishbone_rw_master_if.sv
// apf_wishbone_rw_master_if: classic Wishbone bus between the
// APF master and the SDRAM/CSR interconnect.
interface apf_wishbone_rw_master_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0]   adr;
  logic [DATA_W-1:0]   dat_w;
  logic [DATA_W-1:0]   dat_r;
  logic [DATA_W/8-1:0] sel;
  logic                cyc;
  logic                stb;
  logic                we;
  logic [2:0]          cti;
  logic [1:0]          bte;
  logic                ack;
  logic                err;

  modport master (
    output adr, dat_w, sel, cyc, stb, we, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, cyc, stb, we, cti, bte,
    output dat_r, ack, err
  );

endinterface

// File: rtl/apf_wb_cmd_fifo.sv
// apf_wb_cmd_fifo: synchronous command FIFO with a registered read port.
// Popped data appears on rd_data the cycle after rd_en.
module apf_wb_cmd_fifo
  import apf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic wr_en,
  input  cmd_t wr_data,
  input  logic rd_en,
  output cmd_t rd_data,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  cmd_t        mem [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic        do_wr;
  logic        do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[PW-1:0]] <= wr_data;
    end
  end

  // Pointers and the registered head read.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_data <= mem[rd_ptr[PW-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/apf_wishbone_rw_master.sv
// apf_wishbone_rw_master: queued classic-cycle Wishbone master for APF.
// Define APF_WB_TIMEOUT_EN to abort cycles not acked in TIMEOUT_CYCLES.
module apf_wishbone_rw_master
  import apf_wb_pkg::*;
#(
  parameter int ADDR_W         = WB_ADDR_W,
  parameter int DATA_W         = WB_DATA_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   base_word,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W/8-1:0] cmd_sel,
  input  logic                cmd_swap,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                err_sticky,
  output logic                busy,
  apf_wishbone_rw_master_if.master wb
);

  if (ADDR_W != WB_ADDR_W || DATA_W != WB_DATA_W) begin : g_bad_w
    $error("ADDR_W/DATA_W must match apf_wb_pkg");
  end
  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  state_t state;
  cmd_t   wr_cmd;
  cmd_t   rd_cmd;
  logic   full;
  logic   empty;
  logic   pop;
  logic   fetch;
  logic   swap_q;
  logic   tmo_hit;
  logic   abort;
  logic   term;

  assign wr_cmd = '{
    we:   cmd_we,
    swap: cmd_swap,
    sel:  cmd_sel,
    addr: cmd_addr,
    data: cmd_data
  };

  assign cmd_ready = !full;
  assign pop       = (state == IDLE) && !fetch && !empty;
  assign busy      = !empty || fetch || (state != IDLE);
  assign wb.cti    = 3'b000;
  assign wb.bte    = 2'b00;

  apf_wb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_sys),
    .reset   (reset),
    .wr_en   (cmd_valid),
    .wr_data (wr_cmd),
    .rd_en   (pop),
    .rd_data (rd_cmd),
    .full    (full),
    .empty   (empty)
  );

`ifdef APF_WB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in BUS waiting for a termination.
  always_ff @(posedge clk_sys) begin
    if (reset || state != BUS || wb.ack || wb.err) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // A timeout only counts as an abort when the slave stays silent.
  assign abort = tmo_hit && !wb.ack && !wb.err;
  assign term  = wb.ack || wb.err || tmo_hit;

  // Command sequencer: fetch, one bus cycle, then hold any read response.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      fetch      <= 1'b0;
      swap_q     <= 1'b0;
      wb.cyc     <= 1'b0;
      wb.stb     <= 1'b0;
      wb.we      <= 1'b0;
      wb.adr     <= '0;
      wb.dat_w   <= '0;
      wb.sel     <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
      err_sticky <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fetch) begin
            fetch    <= 1'b0;
            swap_q   <= rd_cmd.swap;
            wb.cyc   <= 1'b1;
            wb.stb   <= 1'b1;
            wb.we    <= rd_cmd.we;
            wb.adr   <= rd_cmd.addr + base_word;
            wb.dat_w <= rd_cmd.swap ? byte_rev(rd_cmd.data)
                                    : rd_cmd.data;
            wb.sel   <= rd_cmd.swap ? sel_rev(rd_cmd.sel)
                                    : rd_cmd.sel;
            state    <= BUS;
          end else if (pop) begin
            fetch <= 1'b1;
          end
        end
        BUS: begin
          if (term) begin
            wb.cyc <= 1'b0;
            wb.stb <= 1'b0;
            wb.we  <= 1'b0;
            if (wb.err || abort) begin
              err_sticky <= 1'b1;
            end
            if (wb.we) begin
              state <= IDLE;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= wb.err || abort;
              if (abort) begin
                rsp_data <= '0;
              end else begin
                rsp_data <= swap_q ? byte_rev(wb.dat_r) : wb.dat_r;
              end
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apf_wishbone_rw_master.sv
// tb_apf_wishbone_rw_master: directed table plus corner sequences
// for the APF Wishbone read/write master.
module tb_apf_wishbone_rw_master;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] base_word = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [29:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  cmd_sel = '0;
  logic        cmd_swap = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        err_sticky;
  logic        busy;

  apf_wishbone_rw_master_if #(.ADDR_W(30), .DATA_W(32)) wb();

  apf_wishbone_rw_master #(
    .ADDR_W(30), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .base_word(base_word),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_sel(cmd_sel),
    .cmd_swap(cmd_swap), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .err_sticky(err_sticky),
    .busy(busy), .wb(wb)
  );

  initial forever #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        we;
    logic [29:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          cyc_no;
  } txn_t;

  txn_t log_q[$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_no = 0;
  int   slv_delay = 0;
  int   wcnt = 0;
  bit   slv_stall = 1'b0;
  bit   slv_err = 1'b0;
  bit   slv_force = 1'b0;
  bit   slv_drove = 1'b0;
  logic [31:0] slv_rdata = '0;

  // Slave model: acks after slv_delay cycles, logs each terminated cycle.
  initial begin
    wb.ack = 1'b0;
    wb.err = 1'b0;
    wb.dat_r = '0;
    forever begin
      @(posedge clk_sys);
      #1;
      cyc_no++;
      if (slv_force) begin
        wb.ack = 1'b1;
        slv_drove = 1'b1;
      end else if (slv_drove) begin
        wb.ack = 1'b0;
        wb.err = 1'b0;
        slv_drove = 1'b0;
      end else if (wb.cyc && wb.stb && !slv_stall) begin
        if (wcnt >= slv_delay) begin
          log_q.push_back('{wb.we, wb.adr, wb.dat_w, wb.sel, cyc_no});
          wb.ack = !slv_err;
          wb.err = slv_err;
          wb.dat_r = slv_rdata;
          slv_drove = 1'b1;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(logic we, logic [29:0] a, logic [31:0] d,
                      logic [3:0] s, logic sw);
    int k = 0;
    cmd_valid = 1'b1;
    cmd_we = we;
    cmd_addr = a;
    cmd_data = d;
    cmd_sel = s;
    cmd_swap = sw;
    while (!cmd_ready && k < 300) begin
      tick();
      k++;
    end
    if (k >= 300) chk("push_timeout", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_log(string nm, int n);
    int k = 0;
    while (log_q.size() < n && k < 300) begin
      tick();
      k++;
    end
    chk({nm, "_cnt"}, 64'(log_q.size()), 64'(n));
  endtask

  task automatic wait_idle(string nm);
    int k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    chk({nm, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic get_rsp(string nm, logic [31:0] ed, logic ee);
    int k = 0;
    while (!rsp_valid && k < 300) begin
      tick();
      k++;
    end
    chk({nm, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({nm, "_data"}, 64'(rsp_data), 64'(ed));
    chk({nm, "_err"}, 64'(rsp_err), 64'(ee));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({nm, "_drop"}, 64'(rsp_valid), 64'd0);
  endtask

  task automatic wait_cyc(string nm);
    int k = 0;
    while (!wb.cyc && k < 300) begin
      tick();
      k++;
    end
    chk({nm, "_cyc_up"}, 64'(wb.cyc), 64'd1);
  endtask

  typedef struct {
    logic        we;
    logic [29:0] base;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        swap;
    logic [31:0] rdata;
    logic        err;
    int          delay;
    logic [29:0] e_adr;
    logic [31:0] e_dat;
    logic [3:0]  e_sel;
    logic [31:0] e_rsp;
    logic        e_rerr;
    logic        e_sticky;
  } vec_t;

  vec_t vt[8];

  initial begin
    int   n0;
    int   cnt;
    txn_t t;

    vt[0] = '{1, 30'h100, 30'h10, 32'hA1B2C3D4, 4'hF, 0, 32'h0, 0, 2,
              30'h110, 32'hA1B2C3D4, 4'hF, 32'h0, 0, 0};
    vt[1] = '{0, 30'h100, 30'h4, 32'h0, 4'hF, 1, 32'h11223344, 0, 1,
              30'h104, 32'h0, 4'hF, 32'h44332211, 0, 0};
    vt[2] = '{1, 30'h0, 30'h20, 32'h01020304, 4'h3, 1, 32'h0, 0, 0,
              30'h20, 32'h04030201, 4'hC, 32'h0, 0, 0};
    vt[3] = '{1, 30'h2, 30'h3FFFFFFF, 32'hDEADBEEF, 4'h5, 0, 32'h0, 0, 0,
              30'h1, 32'hDEADBEEF, 4'h5, 32'h0, 0, 0};
    vt[4] = '{0, 30'h3FFFFF00, 30'h1FF, 32'h0, 4'hF, 0, 32'h89ABCDEF,
              0, 3, 30'hFF, 32'h0, 4'hF, 32'h89ABCDEF, 0, 0};
    vt[5] = '{1, 30'h0, 30'h40, 32'h12345678, 4'hF, 0, 32'h0, 1, 1,
              30'h40, 32'h12345678, 4'hF, 32'h0, 0, 1};
    vt[6] = '{0, 30'h0, 30'h44, 32'h0, 4'h6, 1, 32'hCAFEF00D, 1, 0,
              30'h44, 32'h0, 4'h6, 32'h0DF0FECA, 1, 1};
    vt[7] = '{1, 30'h0, 30'h48, 32'h0, 4'h8, 1, 32'h0, 0, 0,
              30'h48, 32'h0, 4'h1, 32'h0, 0, 1};

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_cyc", 64'(wb.cyc), 64'd0);
    chk("rst_stb", 64'(wb.stb), 64'd0);
    chk("rst_we", 64'(wb.we), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_sticky", 64'(err_sticky), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_cti_bte", 64'({wb.cti, wb.bte}), 64'd0);

    // Push at edge N must raise cyc at edge N+2
    slv_stall = 1'b1;
    base_word = 30'h0;
    n0 = log_q.size();
    push(1'b1, 30'h7, 32'h5A5A5A5A, 4'hF, 1'b0);
    chk("lat_n0_cyc", 64'(wb.cyc), 64'd0);
    chk("lat_n0_busy", 64'(busy), 64'd1);
    tick();
    chk("lat_n1_cyc", 64'(wb.cyc), 64'd0);
    tick();
    chk("lat_n2_cyc", 64'({wb.cyc, wb.stb}), 64'd3);
    slv_stall = 1'b0;
    wait_log("lat", n0 + 1);
    wait_idle("lat");

    // Table of single commands
    for (int i = 0; i < 8; i++) begin
      base_word = vt[i].base;
      slv_rdata = vt[i].rdata;
      slv_err = vt[i].err;
      slv_delay = vt[i].delay;
      n0 = log_q.size();
      push(vt[i].we, vt[i].addr, vt[i].data, vt[i].sel, vt[i].swap);
      wait_log($sformatf("v%0d", i), n0 + 1);
      if (log_q.size() > n0) begin
        t = log_q[n0];
        chk($sformatf("v%0d_adr", i), 64'(t.adr), 64'(vt[i].e_adr));
        chk($sformatf("v%0d_dat", i), 64'(t.dat), 64'(vt[i].e_dat));
        chk($sformatf("v%0d_sel", i), 64'(t.sel), 64'(vt[i].e_sel));
        chk($sformatf("v%0d_we", i), 64'(t.we), 64'(vt[i].we));
      end
      if (!vt[i].we) begin
        get_rsp($sformatf("v%0d_rsp", i), vt[i].e_rsp, vt[i].e_rerr);
      end
      wait_idle($sformatf("v%0d", i));
      chk($sformatf("v%0d_one", i), 64'(log_q.size()), 64'(n0 + 1));
      chk($sformatf("v%0d_sticky", i), 64'(err_sticky),
          64'(vt[i].e_sticky));
    end
    slv_err = 1'b0;
    slv_delay = 0;

    // Response held with rsp_ready low; queued write must wait
    base_word = 30'h100;
    slv_rdata = 32'h55667788;
    n0 = log_q.size();
    push(1'b0, 30'h4, 32'h0, 4'hF, 1'b1);
    push(1'b1, 30'h8, 32'h0BADCAFE, 4'hF, 1'b0);
    cnt = 0;
    while (!rsp_valid && cnt < 300) begin
      tick();
      cnt++;
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d_valid", i), 64'(rsp_valid), 64'd1);
      chk($sformatf("hold%0d_data", i), 64'(rsp_data), 64'h88776655);
      chk($sformatf("hold%0d_cyc", i), 64'(wb.cyc), 64'd0);
      tick();
    end
    chk("hold_log", 64'(log_q.size()), 64'(n0 + 1));
    get_rsp("hold_rsp", 32'h88776655, 1'b0);
    wait_log("hold_wr", n0 + 2);
    wait_idle("hold");
    if (log_q.size() > n0 + 1) begin
      chk("hold_wr_adr", 64'(log_q[n0+1].adr), 64'h108);
      chk("hold_wr_dat", 64'(log_q[n0+1].dat), 64'h0BADCAFE);
    end

    // Five commands against a stalled slave fill the FIFO
    base_word = 30'h0;
    slv_stall = 1'b1;
    n0 = log_q.size();
    for (int i = 0; i < 5; i++) begin
      push(1'b1, 30'h80 + 30'(i), 32'(i), 4'hF, 1'b0);
    end
    chk("full_ready", 64'(cmd_ready), 64'd0);
    repeat (6) tick();
    chk("full_ready_hold", 64'(cmd_ready), 64'd0);
    chk("full_cyc_hold", 64'(wb.cyc), 64'd1);
    chk("full_no_txn", 64'(log_q.size()), 64'(n0));
    slv_stall = 1'b0;
    wait_log("full", n0 + 5);
    wait_idle("full");
    chk("full_ready_back", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (log_q.size() > n0 + i) begin
        chk($sformatf("full%0d_adr", i), 64'(log_q[n0+i].adr),
            64'(30'h80 + 30'(i)));
        chk($sformatf("full%0d_dat", i), 64'(log_q[n0+i].dat), 64'(i));
        if (i > 0) begin
          chk($sformatf("full%0d_gap", i),
              64'(log_q[n0+i].cyc_no - log_q[n0+i-1].cyc_no), 64'd3);
        end
      end
    end

    // Reset in the middle of a bus cycle, with a stray ack
    slv_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 30'h200 + 30'(i), 32'hFFFF0000, 4'hF, 1'b0);
    end
    wait_cyc("mid");
    n0 = log_q.size();
    reset = 1'b1;
    slv_force = 1'b1;
    tick();
    chk("mid_cyc", 64'({wb.cyc, wb.stb}), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_sticky", 64'(err_sticky), 64'd0);
    chk("mid_ready", 64'(cmd_ready), 64'd1);
    reset = 1'b0;
    tick();
    slv_force = 1'b0;
    slv_stall = 1'b0;
    repeat (8) tick();
    chk("mid_after_cyc", 64'(wb.cyc), 64'd0);
    chk("mid_after_busy", 64'(busy), 64'd0);
    chk("mid_after_rsp", 64'(rsp_valid), 64'd0);
    chk("mid_after_log", 64'(log_q.size()), 64'(n0));
    slv_rdata = 32'h0F1E2D3C;
    push(1'b0, 30'h300, 32'h0, 4'hF, 1'b0);
    get_rsp("mid_new", 32'h0F1E2D3C, 1'b0);
    wait_idle("mid_new");

`ifdef APF_WB_TIMEOUT_EN
    // Read never acked: aborted after 8 cycles as an error
    slv_stall = 1'b1;
    push(1'b0, 30'h400, 32'h0, 4'hF, 1'b0);
    wait_cyc("tmo");
    cnt = 0;
    while (wb.cyc && cnt < 50) begin
      cnt++;
      tick();
    end
    chk("tmo_len", 64'(cnt), 64'd8);
    get_rsp("tmo_rsp", 32'h0, 1'b1);
    chk("tmo_sticky", 64'(err_sticky), 64'd1);
    slv_stall = 1'b0;
    wait_idle("tmo");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
